// File: rtl/axis_strm_arb_pkg.sv
// Shared types and constants for the packet-granular AXI-Stream arbiter.
// Holds the soft register request/response structs, the forward half of an
// AXI-Stream beat, the arbiter FSM states and the soft register address map.
package axis_strm_arb_pkg;

  // Soft register request: one transaction per cycle when valid is high.
  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
  } SoftRegReq;

  // Soft register response: valid for one cycle, carries read data.
  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;

  localparam int unsigned TDATA_W = 512;
  localparam int unsigned TDEST_W = 5;
  localparam int unsigned TID_W   = 5;

  // Source-to-sink half of an AXI-Stream channel; tready travels separately.
  typedef struct packed {
    logic [TDATA_W-1:0] tdata;
    logic [TDEST_W-1:0] tdest;
    logic [TID_W-1:0]   tid;
    logic               tlast;
    logic               tvalid;
  } axis_fwd_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Grant index is always 3 bits so the status layout is fixed for 2..8 ports.
  localparam int unsigned GRANT_W = 3;
  localparam int unsigned PKT_W   = 48;

  localparam logic [31:0] ADDR_MASK        = 32'h0000_0000;
  localparam logic [31:0] ADDR_BEAT_BASE   = 32'h0000_0008;
  localparam logic [31:0] ADDR_BEAT_STRIDE = 32'h0000_0008;
  localparam logic [31:0] ADDR_PKT         = 32'h0000_0048;
  localparam logic [31:0] ADDR_STATUS      = 32'h0000_0050;

  // Address of the beat counter belonging to port p.
  function automatic logic [31:0] beat_addr(input int p);
    return ADDR_BEAT_BASE + ADDR_BEAT_STRIDE * 32'(p);
  endfunction

endpackage

// File: rtl/axis_strm_arb_rr_pick.sv
// Round-robin priority picker (purely combinational).
// Scans the request vector starting at (last_i + 1) mod N and reports the
// first requesting index.
//   req_i   : request vector, one bit per port
//   last_i  : index of the most recently served port (must be < N)
//   found_o : at least one request is pending
//   idx_o   : chosen port index (0 when nothing is found)
module rr_pick
  import axis_strm_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Offset k = 1..N visits every port exactly once, lowest offset wins.
  // Comparing against every port avoids a variable bit-select into req_i.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = 1; k <= int'(N); k++) begin
      for (int p = 0; p < int'(N); p++) begin
        if (!found_o && req_i[p] && ((int'(last_i) + k) % int'(N)) == p) begin
          found_o = 1'b1;
          idx_o   = IW'(p);
        end
      end
    end
  end

endmodule

// File: rtl/axis_strm_arb.sv
// Packet-granular round-robin AXI-Stream arbiter with soft register control.
// An IDLE cycle picks the next enabled, valid port; LOCK then forwards that
// port verbatim (tid replaced by the port number) until its tlast handshake.
//   clk, rst         : clock and asynchronous active-high reset
//   softreg_req      : soft register request (valid, isWrite, addr, data)
//   softreg_resp     : soft register read response, one cycle after request
//   axis_in          : forward signals of NUM_IN requester streams
//   axis_in_tready   : per-requester tready
//   axis_out         : forward signals of the shared output stream
//   axis_out_tready  : output stream tready
module axis_strm_arb
  import axis_strm_arb_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned CNT_W  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  SoftRegReq         softreg_req,
  output SoftRegResp        softreg_resp,
  input  axis_fwd_t         axis_in [NUM_IN],
  output logic [NUM_IN-1:0] axis_in_tready,
  output axis_fwd_t         axis_out,
  input  logic              axis_out_tready
);

  arb_state_t         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] last_q, last_d;
  logic [NUM_IN-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0]   beat_q [NUM_IN];
  logic [CNT_W-1:0]   beat_d [NUM_IN];
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  SoftRegResp         resp_q, resp_d;

  logic [NUM_IN-1:0]  req_vec;
  logic               pick_found;
  logic [GRANT_W-1:0] pick_idx;
  logic               hs;
  logic               hs_last;

  logic               sr_wr;
  logic               sr_rd;
  logic [NUM_IN-1:0]  beat_clr;
  logic               pkt_clr;
  logic [63:0]        rdata;

  // Upper write-data bits only matter for the mask register width.
  logic               unused_wdata;
  assign unused_wdata = ^softreg_req.data[63:NUM_IN];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    req_vec = '0;
    for (int p = 0; p < int'(NUM_IN); p++) begin
      req_vec[p] = mask_q[p] & axis_in[p].tvalid;
    end
  end

  rr_pick #(
    .N  (NUM_IN),
    .IW (GRANT_W)
  ) u_rr_pick (
    .req_i   (req_vec),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Output mux: nothing is forwarded in IDLE, which yields the one-cycle
  // bubble between packets.
  always_comb begin
    axis_out       = '0;
    axis_in_tready = '0;
    if (state_q == LOCK) begin
      for (int p = 0; p < int'(NUM_IN); p++) begin
        if (grant_q == GRANT_W'(p)) begin
          axis_out          = axis_in[p];
          axis_out.tid      = TID_W'(grant_q);
          axis_in_tready[p] = axis_out_tready;
        end
      end
    end
  end

  assign hs      = axis_out.tvalid & axis_out_tready;
  assign hs_last = hs & axis_out.tlast;

  // The mask is only consulted here in IDLE, so disabling the granted port
  // never truncates a packet in flight.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (hs_last) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Soft registers
  // ---------------------------------------------------------------------------
  assign sr_wr   = softreg_req.valid & softreg_req.isWrite;
  assign sr_rd   = softreg_req.valid & ~softreg_req.isWrite;
  assign pkt_clr = sr_wr && (softreg_req.addr == ADDR_PKT);

  always_comb begin
    beat_clr = '0;
    for (int p = 0; p < int'(NUM_IN); p++) begin
      beat_clr[p] = sr_wr && (softreg_req.addr == beat_addr(p));
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (sr_wr && (softreg_req.addr == ADDR_MASK)) begin
      mask_d = softreg_req.data[NUM_IN-1:0];
    end
  end

  // Clear takes priority over a same-edge increment.
  always_comb begin
    beat_d = beat_q;
    for (int p = 0; p < int'(NUM_IN); p++) begin
      if (beat_clr[p]) begin
        beat_d[p] = '0;
      end else if (hs && (grant_q == GRANT_W'(p))) begin
        beat_d[p] = beat_q[p] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pkt_d = pkt_q;
    if (pkt_clr) begin
      pkt_d = '0;
    end else if (hs_last) begin
      pkt_d = pkt_q + PKT_W'(1);
    end
  end

  // Read mux; unmapped addresses fall through to zero.
  always_comb begin
    rdata = '0;
    if (softreg_req.addr == ADDR_MASK) begin
      rdata = 64'(mask_q);
    end else if (softreg_req.addr == ADDR_PKT) begin
      rdata = 64'(pkt_q);
    end else if (softreg_req.addr == ADDR_STATUS) begin
      rdata = 64'({state_q, 5'b0_0000, grant_q});
    end
    for (int p = 0; p < int'(NUM_IN); p++) begin
      if (softreg_req.addr == beat_addr(p)) begin
        rdata = 64'(beat_q[p]);
      end
    end
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = sr_rd;
    if (sr_rd) begin
      resp_d.data = rdata;
    end
  end

  assign softreg_resp = resp_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // last_q resets to NUM_IN-1 so port 0 is the first port scanned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GRANT_W'(NUM_IN - 1);
      mask_q  <= '0;
      beat_q  <= '{default: '0};
      pkt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_axis_strm_arb.sv
// Self-checking bench for axis_strm_arb: a table of per-cycle vectors for
// round-robin rotation, plus hand-written sequences for the multi-cycle cases.
module tb_axis_strm_arb;
  import axis_strm_arb_pkg::*;

  localparam int NUM_IN = 4;
  localparam int CNT_W  = 48;

  logic              clk = 1'b0;
  logic              rst;
  SoftRegReq         sreq;
  SoftRegResp        sresp;
  axis_fwd_t         ain [NUM_IN];
  logic [NUM_IN-1:0] ain_rdy;
  axis_fwd_t         aout;
  logic              aout_rdy;

  logic [3:0]   tv;
  logic [3:0]   tl;
  logic [511:0] td [NUM_IN];

  int n_cmp = 0;
  int n_err = 0;

  // Scratch state for the stalled-packet sequence.
  int          bi;
  int          cy;
  int          rcv;
  logic [15:0] got [8];
  logic [7:0]  rpat;

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < NUM_IN; p++) begin
      ain[p].tdata  = td[p];
      ain[p].tdest  = 5'(p);
      ain[p].tid    = 5'b1_1111;
      ain[p].tlast  = tl[p];
      ain[p].tvalid = tv[p];
    end
  end

  axis_strm_arb #(
    .NUM_IN (NUM_IN),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .softreg_req     (sreq),
    .softreg_resp    (sresp),
    .axis_in         (ain),
    .axis_in_tready  (ain_rdy),
    .axis_out        (aout),
    .axis_out_tready (aout_rdy)
  );

  typedef struct {
    logic [3:0] tv;
    logic [3:0] tl;
    logic       ov;
    logic [2:0] g;
    logic       ol;
    logic [3:0] rdy;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Compares the output stream and tready vector; when a beat is expected the
  // forwarded data must be the granted port's own data.
  task automatic chk_out(input string name, input logic eov, input logic [2:0] eg,
                         input logic elast, input logic [3:0] erdy);
    if (eov) begin
      check(name, {aout.tvalid, aout.tid, aout.tdest, aout.tlast, ain_rdy, aout.tdata[15:0]},
            {1'b1, 2'b00, eg, 2'b00, eg, elast, erdy, td[int'(eg)][15:0]});
    end else begin
      check(name, {aout.tvalid, ain_rdy}, {1'b0, erdy});
    end
  endtask

  // One cycle: drive at the negedge, check 1 ns later, advance to next negedge.
  task automatic cyc_chk(input string name, input logic [3:0] tvv, input logic [3:0] tlv,
                         input logic rdy, input logic eov, input logic [2:0] eg,
                         input logic elast, input logic [3:0] erdy);
    tv       = tvv;
    tl       = tlv;
    aout_rdy = rdy;
    #1;
    chk_out(name, eov, eg, elast, erdy);
    @(negedge clk);
  endtask

  task automatic sreg_write(input logic [31:0] a, input logic [63:0] d);
    sreq.valid   = 1'b1;
    sreq.isWrite = 1'b1;
    sreq.addr    = a;
    sreq.data    = d;
    @(negedge clk);
    sreq = '0;
  endtask

  task automatic chk_reg(input string name, input logic [31:0] a, input logic [63:0] e);
    sreq.valid   = 1'b1;
    sreq.isWrite = 1'b0;
    sreq.addr    = a;
    sreq.data    = '0;
    @(negedge clk);
    sreq = '0;
    check(name, {sresp.valid, sresp.data}, {1'b1, e});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sreq     = '0;
    tv       = 4'hF;
    tl       = '0;
    aout_rdy = 1'b1;
    rst      = 1'b1;
    for (int p = 0; p < NUM_IN; p++) td[p] = 512'(16'hA000 + p);

    // Outputs held quiet during reset even with every port valid.
    repeat (2) @(negedge clk);
    #1;
    chk_out("rst_outputs", 1'b0, 3'd0, 1'b0, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    chk_reg("rst_status", ADDR_STATUS, 64'h0);
    chk_reg("rst_mask", ADDR_MASK, 64'h0);
    chk_reg("rst_pkt", ADDR_PKT, 64'h0);
    chk_reg("rst_beat0", 32'h08, 64'h0);

    // Mask is zero: valid ports must not be granted.
    cyc_chk("mask0_idle_a", 4'hF, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    cyc_chk("mask0_idle_b", 4'hF, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    chk_reg("mask0_status", ADDR_STATUS, 64'h0);
    tv = 4'h0;

    sreg_write(ADDR_MASK, 64'hF);
    check("wr_no_resp", {63'h0, sresp.valid}, 64'h0);
    chk_reg("mask_f", ADDR_MASK, 64'hF);

    // All ports valid, 2-beat packets: tid 0,1,2,3,0 with one bubble between.
    tbl[0]  = '{4'hF, 4'h0, 1'b0, 3'd0, 1'b0, 4'h0};
    tbl[1]  = '{4'hF, 4'h0, 1'b1, 3'd0, 1'b0, 4'h1};
    tbl[2]  = '{4'hF, 4'h1, 1'b1, 3'd0, 1'b1, 4'h1};
    tbl[3]  = '{4'hF, 4'h0, 1'b0, 3'd0, 1'b0, 4'h0};
    tbl[4]  = '{4'hF, 4'h0, 1'b1, 3'd1, 1'b0, 4'h2};
    tbl[5]  = '{4'hF, 4'h2, 1'b1, 3'd1, 1'b1, 4'h2};
    tbl[6]  = '{4'hF, 4'h0, 1'b0, 3'd0, 1'b0, 4'h0};
    tbl[7]  = '{4'hF, 4'h0, 1'b1, 3'd2, 1'b0, 4'h4};
    tbl[8]  = '{4'hF, 4'h4, 1'b1, 3'd2, 1'b1, 4'h4};
    tbl[9]  = '{4'hF, 4'h0, 1'b0, 3'd0, 1'b0, 4'h0};
    tbl[10] = '{4'hF, 4'h0, 1'b1, 3'd3, 1'b0, 4'h8};
    tbl[11] = '{4'hF, 4'h8, 1'b1, 3'd3, 1'b1, 4'h8};
    tbl[12] = '{4'hF, 4'h0, 1'b0, 3'd0, 1'b0, 4'h0};
    tbl[13] = '{4'hF, 4'h0, 1'b1, 3'd0, 1'b0, 4'h1};
    tbl[14] = '{4'hF, 4'h1, 1'b1, 3'd0, 1'b1, 4'h1};
    for (int i = 0; i < 15; i++) begin
      cyc_chk($sformatf("rr_row%0d", i), tbl[i].tv, tbl[i].tl, 1'b1,
              tbl[i].ov, tbl[i].g, tbl[i].ol, tbl[i].rdy);
    end
    tv = 4'h0;
    tl = 4'h0;
    chk_reg("rr_pkt", ADDR_PKT, 64'd5);
    chk_reg("rr_beat0", 32'h08, 64'd4);
    chk_reg("rr_beat3", 32'h20, 64'd2);

    // Port 2 alone sends a 3-beat packet; status read while locked.
    do_reset();
    sreg_write(ADDR_MASK, 64'hF);
    cyc_chk("p2_bubble", 4'h4, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    sreq.valid   = 1'b1;
    sreq.isWrite = 1'b0;
    sreq.addr    = ADDR_STATUS;
    cyc_chk("p2_beat0", 4'h4, 4'h0, 1'b1, 1'b1, 3'd2, 1'b0, 4'h4);
    sreq = '0;
    check("p2_status_lock", {sresp.valid, sresp.data}, {1'b1, 64'h102});
    cyc_chk("p2_beat1", 4'h4, 4'h0, 1'b1, 1'b1, 3'd2, 1'b0, 4'h4);
    cyc_chk("p2_beat2", 4'h4, 4'h4, 1'b1, 1'b1, 3'd2, 1'b1, 4'h4);
    cyc_chk("p2_done", 4'h0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    chk_reg("p2_beat2_cnt", 32'h18, 64'd3);
    chk_reg("p2_pkt", ADDR_PKT, 64'd1);
    chk_reg("p2_status_idle", ADDR_STATUS, 64'h002);

    // Port 1 sends 4 beats while output tready toggles.
    bi   = 0;
    cy   = 0;
    rcv  = 0;
    rpat = 8'b1111_0101;
    td[1] = 512'(16'h0100);
    cyc_chk("p1_bubble", 4'h2, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    while (bi < 4 && cy < 20) begin
      td[1]    = 512'(16'h0100 + bi);
      tl       = (bi == 3) ? 4'h2 : 4'h0;
      tv       = 4'h2;
      aout_rdy = rpat[cy[2:0]];
      #1;
      check("p1_stall_out",
            {aout.tvalid, aout.tid, ain_rdy, aout.tdata[15:0], aout.tlast},
            {1'b1, 5'd1, (aout_rdy ? 4'h2 : 4'h0), 16'(16'h0100 + bi), (bi == 3)});
      if (aout_rdy && aout.tvalid) begin
        got[rcv[2:0]] = aout.tdata[15:0];
        rcv++;
      end
      if (ain_rdy[1]) bi++;
      cy++;
      @(negedge clk);
    end
    aout_rdy = 1'b1;
    check("p1_src_done", 96'(bi), 96'd4);
    check("p1_beats_rcvd", 96'(rcv), 96'd4);
    for (int k = 0; k < 4; k++) check("p1_beat_data", 96'(got[k]), 96'(16'h0100 + k));
    cyc_chk("p1_done", 4'h0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    chk_reg("p1_beat1_cnt", 32'h10, 64'd4);

    // Mask drops to port 0 while port 3 is mid-packet.
    cyc_chk("p3_bubble", 4'h8, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    sreq.valid   = 1'b1;
    sreq.isWrite = 1'b1;
    sreq.addr    = ADDR_MASK;
    sreq.data    = 64'h1;
    cyc_chk("p3_beat0", 4'h9, 4'h0, 1'b1, 1'b1, 3'd3, 1'b0, 4'h8);
    sreq = '0;
    cyc_chk("p3_beat1", 4'h9, 4'h0, 1'b1, 1'b1, 3'd3, 1'b0, 4'h8);
    cyc_chk("p3_beat2", 4'h9, 4'h8, 1'b1, 1'b1, 3'd3, 1'b1, 4'h8);
    cyc_chk("m1_bubble_a", 4'h9, 4'h9, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    cyc_chk("m1_p0_a", 4'h9, 4'h9, 1'b1, 1'b1, 3'd0, 1'b1, 4'h1);
    cyc_chk("m1_bubble_b", 4'h9, 4'h9, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    cyc_chk("m1_p0_b", 4'h9, 4'h9, 1'b1, 1'b1, 3'd0, 1'b1, 4'h1);
    cyc_chk("m1_done", 4'h0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    chk_reg("m1_pkt", ADDR_PKT, 64'd5);
    chk_reg("m1_beat3_cnt", 32'h20, 64'd3);
    chk_reg("m1_mask", ADDR_MASK, 64'h1);

    // Packet counter clear, then unmapped reads.
    sreg_write(ADDR_PKT, 64'h0);
    chk_reg("pkt_cleared", ADDR_PKT, 64'h0);
    chk_reg("unmapped_04", 32'h04, 64'h0);
    chk_reg("unmapped_28", 32'h28, 64'h0);
    chk_reg("unmapped_100", 32'h100, 64'h0);

    // beat_cnt[0] cleared on the same edge as a port-0 handshake.
    cyc_chk("clr_bubble", 4'h1, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    cyc_chk("clr_beat0", 4'h1, 4'h0, 1'b1, 1'b1, 3'd0, 1'b0, 4'h1);
    sreq.valid   = 1'b1;
    sreq.isWrite = 1'b1;
    sreq.addr    = 32'h08;
    sreq.data    = 64'h0;
    cyc_chk("clr_beat1", 4'h1, 4'h1, 1'b1, 1'b1, 3'd0, 1'b1, 4'h1);
    sreq = '0;
    tv = 4'h0;
    tl = 4'h0;
    chk_reg("clr_wins", 32'h08, 64'h0);
    chk_reg("clr_pkt", ADDR_PKT, 64'd1);

    // Reset in the middle of a port-1 packet.
    sreg_write(ADDR_MASK, 64'hF);
    cyc_chk("rp_bubble", 4'h2, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    cyc_chk("rp_beat0", 4'h2, 4'h0, 1'b1, 1'b1, 3'd1, 1'b0, 4'h2);
    rst = 1'b1;
    #1;
    chk_out("rp_in_reset", 1'b0, 3'd0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tv  = 4'h0;
    @(negedge clk);
    chk_reg("rp_status", ADDR_STATUS, 64'h000);
    chk_reg("rp_pkt", ADDR_PKT, 64'h0);
    chk_reg("rp_beat1", 32'h10, 64'h0);
    chk_reg("rp_mask", ADDR_MASK, 64'h0);
    sreg_write(ADDR_MASK, 64'hF);
    cyc_chk("rp_new_bubble", 4'h3, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0, 4'h0);
    cyc_chk("rp_first_p0", 4'h3, 4'h1, 1'b1, 1'b1, 3'd0, 1'b1, 4'h1);
    tv = 4'h0;
    tl = 4'h0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_strm_arb.md
AXIS_STRM_ARB -- requirements
Module: axis_strm_arb

Interface
REQ-001 The module SHALL have parameter NUM_IN, default 4: number of input stream requesters (legal range 2..8).
REQ-002 The module SHALL have parameter CNT_W, default 48: width of the per-port beat counters.
REQ-003 The module SHALL have port clk, input, 1 bit: single user clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port softreg_req, input, SoftRegReq: soft register request (valid, isWrite, addr, data).
REQ-006 The module SHALL have port softreg_resp, output, SoftRegResp: soft register response (valid, data).
REQ-007 The module SHALL have port axis_in[NUM_IN], axi_stream_t.slave array: requester streams (tdata 512, tdest 5, tid 5, tlast, tvalid, tready).
REQ-008 The module SHALL have port axis_out, axi_stream_t.master: the single shared output stream.

Function
REQ-009 The module SHALL implement a two-state FSM: IDLE and LOCK.
REQ-010 In IDLE, the module SHALL search for a port p that is the first port with enable_mask[p] and axis_in[p].tvalid, scanning round-robin from (last_grant+1) mod NUM_IN; if found, grant<=p and state<=LOCK on the next edge.
REQ-011 In IDLE, the module SHALL drive axis_out.tvalid=0 and all axis_in[*].tready=0, giving one bubble cycle per packet.
REQ-012 In LOCK, the module SHALL drive axis_out.tdata/tdest/tlast/tvalid combinationally from axis_in[grant], set axis_out.tid=grant (zero-extended), set axis_in[grant].tready=axis_out.tready, and drive tready=0 to every other port.
REQ-013 In LOCK, on a handshake with tlast=1, the module SHALL set last_grant<=grant, increment pkt_count, and set state<=IDLE.
REQ-014 Grant SHALL be packet-granular: no port switch occurs before the tlast handshake.
REQ-015 Clearing the enable bit of the granted port mid-packet SHALL NOT abort the packet; the mask applies only at the next IDLE arbitration.
REQ-016 When no enabled port is valid in IDLE, the module SHALL remain in IDLE with last_grant unchanged.
REQ-017 Each handshake on port p SHALL increment beat_cnt[p]; counters wrap modulo 2^CNT_W; pkt_count is 48 bits and wraps.
REQ-018 A soft register read SHALL produce softreg_resp.valid exactly 1 cycle after the request, with data zero-extended to 64 bits.
REQ-019 Soft register map: 0x00 enable_mask (R/W, NUM_IN bits); 0x08+8*p beat_cnt[p] (R; any write clears it); 0x48 pkt_count (R; any write clears it); 0x50 status {state, grant} (R; state in bit 8, grant in [2:0]).
REQ-020 A counter clear coinciding with an increment on the same edge SHALL result in 0 (clear wins).
REQ-021 Reads of unmapped addresses SHALL return data 0 with valid asserted.

Reset
REQ-022 While rst is high, the module SHALL force state=IDLE, grant=0, last_grant=NUM_IN-1 (so port 0 has first priority), enable_mask=0, all counters=0, and softreg_resp.valid=0.
REQ-023 While in reset, the outputs SHALL be axis_out.tvalid=0 and all tready=0; reset mid-packet drops the packet without completing it.

Structure
REQ-024 The package SHALL hold the arb_state_t enum {IDLE, LOCK} and the softreg address constants; these belong in the shared package alongside ShellTypes.
REQ-025 The round-robin priority picker (request vector plus last pointer in, one-hot/index and found flag out, purely combinational) SHALL be a sub-module named rr_pick.

Verification
REQ-026 Scenario: mask=0xF, port 2 only sends a 3-beat packet -> grant=2 after 1 bubble, 3 beats on axis_out with tid=2, beat_cnt[2]=3, pkt_count=1.
REQ-027 Scenario: all 4 ports continuously valid with 2-beat packets -> output tid sequence 0,1,2,3,0 with one idle cycle between packets.
REQ-028 Scenario: axis_out.tready toggles 1,0,1 during a 4-beat packet from port 1 -> no beat is lost or duplicated and other ports see tready=0 throughout.
REQ-029 Scenario: mask is written 0xF->0x1 while port 3 is mid-packet -> port 3 finishes its packet, after which only port 0 is granted.
REQ-030 Scenario: beat_cnt[0] is cleared by a write on the same cycle as a port-0 handshake -> a subsequent read at 0x08 returns 0.
REQ-031 Scenario: rst is asserted mid-packet from port 1, then released -> status=0x000, grant starts at port 0, pkt_count=0.
